lsu: RTL and testbench

- Load/store unit between EXU and WBU in the multi-cycle core.
- Accepts one memory operation from EXU over a valid/ready handshake and drives it onto a simple request/response data-memory bus.
- Generates byte strobes and lane-replicated store data; aligns and sign- or zero-extends load data.
- Hands the result to WBU over a second valid/ready handshake. Non-memory instructions pass through with 1-cycle latency.

---
 rtl/lsu_if.sv | 38 +++
 rtl/lsu.sv | 165 ++++++++++++++++
 tb/tb_lsu.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// Bundle of the EXU-side, WBU-side and data-memory-side signals of the LSU.
// slave is the LSU's own view; master is the view of whatever surrounds it.
interface lsu_if;
   logic        in_valid;
   logic        in_ready;
   logic        mem_ren;
   logic        mem_wen;
   logic [2:0]  mem_width;
   logic [31:0] addr;
   logic [31:0] st_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] rdata;
   logic        err;
   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport slave (
      input  in_valid, mem_ren, mem_wen, mem_width, addr, st_data,
      input  out_ready, req_ready, resp_valid, resp_rdata, resp_err,
      output in_ready, out_valid, rdata, err,
      output req_valid, req_wen, req_addr, req_wdata, req_wstrb
   );

   modport master (
      output in_valid, mem_ren, mem_wen, mem_width, addr, st_data,
      output out_ready, req_ready, resp_valid, resp_rdata, resp_err,
      input  in_ready, out_valid, rdata, err,
      input  req_valid, req_wen, req_addr, req_wdata, req_wstrb
   );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one EXU operation at a time onto a request/response data bus.
// Define LSU_MISALIGN_CHECK_EN to fault misaligned half/word accesses without touching the bus.
module lsu #(
   parameter int unsigned TIMEOUT_CYCLES = 0
) (
   input  logic  clk,
   input  logic  rst,
   lsu_if.slave  bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]  state_q, state_d;
   logic        load_q, load_d;
   logic [2:0]  width_q, width_d;
   logic [1:0]  off_q, off_d;
   logic        req_wen_q, req_wen_d;
   logic [31:0] req_addr_q, req_addr_d;
   logic [31:0] req_wdata_q, req_wdata_d;
   logic [3:0]  req_wstrb_q, req_wstrb_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [31:0] cnt_q, cnt_d;

   // Size classes: byte, half, everything else (including undefined codes) is word.
   logic in_is_b, in_is_h, ld_is_b, ld_is_h, ld_unsigned;
   assign in_is_b     = (bus.mem_width == 3'b000) || (bus.mem_width == 3'b100);
   assign in_is_h     = (bus.mem_width == 3'b001) || (bus.mem_width == 3'b101);
   assign ld_is_b     = (width_q == 3'b000) || (width_q == 3'b100);
   assign ld_is_h     = (width_q == 3'b001) || (width_q == 3'b101);
   assign ld_unsigned = (width_q == 3'b100) || (width_q == 3'b101);

   logic [3:0]  strb_in;
   logic [31:0] lane_in;
   always_comb begin
      if (in_is_b) begin
         strb_in = 4'b0001 << bus.addr[1:0];
         lane_in = {4{bus.st_data[7:0]}};
      end else if (in_is_h) begin
         strb_in = 4'b0011 << bus.addr[1:0];
         lane_in = {2{bus.st_data[15:0]}};
      end else begin
         strb_in = 4'b1111;
         lane_in = bus.st_data;
      end
   end

   logic [31:0] shifted, load_ext;
   assign shifted = bus.resp_rdata >> {off_q, 3'b000};
   always_comb begin
      if (ld_is_b)
         load_ext = {{24{shifted[7] & ~ld_unsigned}}, shifted[7:0]};
      else if (ld_is_h)
         load_ext = {{16{shifted[15] & ~ld_unsigned}}, shifted[15:0]};
      else
         load_ext = shifted;
   end

`ifdef LSU_MISALIGN_CHECK_EN
   logic misalign_in;
   assign misalign_in = (in_is_h && bus.addr[0]) ||
                        (!in_is_b && !in_is_h && (bus.addr[1:0] != 2'b00));
`endif

   always_comb begin
      state_d     = state_q;
      load_d      = load_q;
      width_d     = width_q;
      off_d       = off_q;
      req_wen_d   = req_wen_q;
      req_addr_d  = req_addr_q;
      req_wdata_d = req_wdata_q;
      req_wstrb_d = req_wstrb_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      cnt_d       = cnt_q;
      case (state_q)
         S_IDLE: if (bus.in_valid) begin
            width_d = bus.mem_width;
            off_d   = bus.addr[1:0];
            load_d  = bus.mem_ren & ~bus.mem_wen;
            if (!bus.mem_ren && !bus.mem_wen) begin
               state_d = S_DONE;
               rdata_d = 32'd0;
               err_d   = 1'b0;
            end
`ifdef LSU_MISALIGN_CHECK_EN
            else if (misalign_in) begin
               state_d = S_DONE;
               rdata_d = 32'd0;
               err_d   = 1'b1;
            end
`endif
            else begin
               state_d     = S_REQ;
               req_wen_d   = bus.mem_wen;
               req_addr_d  = {bus.addr[31:2], 2'b00};
               req_wdata_d = bus.mem_wen ? lane_in : 32'd0;
               req_wstrb_d = bus.mem_wen ? strb_in : 4'd0;
            end
         end
         S_REQ: if (bus.req_ready) begin
            state_d = S_WAIT;
            cnt_d   = 32'd0;
         end
         S_WAIT: begin
            // A response always wins over a timeout landing in the same cycle.
            if (bus.resp_valid) begin
               state_d = S_DONE;
               err_d   = bus.resp_err;
               rdata_d = load_q ? load_ext : 32'd0;
            end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_CYCLES - 1)) begin
               state_d = S_DONE;
               err_d   = 1'b1;
               rdata_d = 32'd0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         default: if (bus.out_ready) state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         load_q      <= 1'b0;
         width_q     <= 3'd0;
         off_q       <= 2'd0;
         req_wen_q   <= 1'b0;
         req_addr_q  <= 32'd0;
         req_wdata_q <= 32'd0;
         req_wstrb_q <= 4'd0;
         rdata_q     <= 32'd0;
         err_q       <= 1'b0;
         cnt_q       <= 32'd0;
      end else begin
         state_q     <= state_d;
         load_q      <= load_d;
         width_q     <= width_d;
         off_q       <= off_d;
         req_wen_q   <= req_wen_d;
         req_addr_q  <= req_addr_d;
         req_wdata_q <= req_wdata_d;
         req_wstrb_q <= req_wstrb_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.req_valid = (state_q == S_REQ);
   assign bus.req_wen   = req_wen_q;
   assign bus.req_addr  = req_addr_q;
   assign bus.req_wdata = req_wdata_q;
   assign bus.req_wstrb = req_wstrb_q;
   assign bus.rdata     = rdata_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with TIMEOUT_CYCLES=4; checks via immediate assertions.
module tb_lsu;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   lsu_if io ();
   lsu #(.TIMEOUT_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(io));

   int pass_cnt = 0;
   int total_cnt = 0;
   int hs_cnt = 0;

   always @(posedge clk) if (rst && io.req_valid && io.req_ready) hs_cnt <= hs_cnt + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic issue(input logic ren, input logic wen, input logic [2:0] w,
                        input logic [31:0] a, input logic [31:0] sd);
      io.in_valid  = 1'b1;
      io.mem_ren   = ren;
      io.mem_wen   = wen;
      io.mem_width = w;
      io.addr      = a;
      io.st_data   = sd;
      tick();
      io.in_valid  = 1'b0;
   endtask

   task automatic complete(input string tag);
      io.out_ready = 1'b1;
      tick();
      io.out_ready = 1'b0;
      chk({tag, "_idle_in_ready"}, {31'd0, io.in_ready}, 32'd1);
   endtask

   // Full zero-wait transaction: accept, request, response, completion.
   task automatic mem_op(input string tag, input logic ren, input logic wen, input logic [2:0] w,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                         input logic [31:0] resp, input logic rerr,
                         input logic [31:0] exp_rdata, input logic exp_err);
      issue(ren, wen, w, a, sd);
      chk({tag, "_req_valid"}, {31'd0, io.req_valid}, 32'd1);
      chk({tag, "_req_addr"}, io.req_addr, {a[31:2], 2'b00});
      chk({tag, "_req_wstrb"}, {28'd0, io.req_wstrb}, {28'd0, exp_strb});
      if (wen) chk({tag, "_req_wdata"}, io.req_wdata, exp_wdata);
      io.req_ready = 1'b1;
      tick();
      io.req_ready  = 1'b0;
      io.resp_valid = 1'b1;
      io.resp_rdata = resp;
      io.resp_err   = rerr;
      tick();
      io.resp_valid = 1'b0;
      io.resp_err   = 1'b0;
      chk({tag, "_out_valid"}, {31'd0, io.out_valid}, 32'd1);
      chk({tag, "_rdata"}, io.rdata, exp_rdata);
      chk({tag, "_err"}, {31'd0, io.err}, {31'd0, exp_err});
      complete(tag);
   endtask

   initial begin
      int hs0;
      io.in_valid = 1'b0; io.mem_ren = 1'b0; io.mem_wen = 1'b0; io.mem_width = 3'd0;
      io.addr = 32'd0; io.st_data = 32'd0; io.out_ready = 1'b0; io.req_ready = 1'b0;
      io.resp_valid = 1'b0; io.resp_rdata = 32'd0; io.resp_err = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_in_ready", {31'd0, io.in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, io.out_valid}, 32'd0);
      chk("rst_req_valid", {31'd0, io.req_valid}, 32'd0);
      chk("rst_req_wen", {31'd0, io.req_wen}, 32'd0);
      chk("rst_req_addr", io.req_addr, 32'd0);
      chk("rst_req_wdata", io.req_wdata, 32'd0);
      chk("rst_req_wstrb", {28'd0, io.req_wstrb}, 32'd0);
      chk("rst_rdata", io.rdata, 32'd0);
      chk("rst_err", {31'd0, io.err}, 32'd0);
      rst = 1'b1;
      tick();

      // lb at offset 3: byte 0x80 sign-extends
      mem_op("lb", 1, 0, 3'b000, 32'h8000_0003, 32'd0, 4'b0000, 32'd0,
             32'h8011_2233, 0, 32'hFFFF_FF80, 0);
      chk("lb_req_wen", {31'd0, io.req_wen}, 32'd0);

      // sh at offset 2; a response during the REQ handshake cycle must be ignored
      issue(0, 1, 3'b001, 32'h8000_0002, 32'h0000_BEEF);
      chk("sh_req_wen", {31'd0, io.req_wen}, 32'd1);
      chk("sh_req_wstrb", {28'd0, io.req_wstrb}, 32'hC);
      chk("sh_req_wdata", io.req_wdata, 32'hBEEF_BEEF);
      io.req_ready = 1'b1;
      io.resp_valid = 1'b1;
      io.resp_err = 1'b1;
      tick();
      io.req_ready = 1'b0;
      io.resp_valid = 1'b0;
      io.resp_err = 1'b0;
      chk("sh_req_dropped", {31'd0, io.req_valid}, 32'd0);
      chk("sh_early_resp_ignored", {31'd0, io.out_valid}, 32'd0);
      tick();
      chk("sh_wait_hold", {31'd0, io.out_valid}, 32'd0);
      io.resp_valid = 1'b1;
      io.resp_rdata = 32'hFFFF_FFFF;
      tick();
      io.resp_valid = 1'b0;
      chk("sh_out_valid", {31'd0, io.out_valid}, 32'd1);
      chk("sh_rdata", io.rdata, 32'd0);
      chk("sh_err", {31'd0, io.err}, 32'd0);
      complete("sh");

      // Non-memory op: out_valid at accept+1, held 4 cycles under backpressure
      issue(0, 0, 3'b010, 32'h1234_5678, 32'h5555_5555);
      chk("nm_out_valid_c1", {31'd0, io.out_valid}, 32'd1);
      chk("nm_rdata", io.rdata, 32'd0);
      chk("nm_err", {31'd0, io.err}, 32'd0);
      chk("nm_no_req", {31'd0, io.req_valid}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("nm_out_valid_hold", {31'd0, io.out_valid}, 32'd1);
         chk("nm_in_ready_low", {31'd0, io.in_ready}, 32'd0);
         chk("nm_rdata_hold", io.rdata, 32'd0);
      end
      complete("nm");
      chk("nm_out_valid_drop", {31'd0, io.out_valid}, 32'd0);

      // sw with req_ready low for 5 cycles; bus error reported
      hs0 = hs_cnt;
      issue(0, 1, 3'b010, 32'h0000_1004, 32'h1234_5678);
      for (int i = 0; i < 5; i++) begin
         chk("sw_stall_req_valid", {31'd0, io.req_valid}, 32'd1);
         chk("sw_stall_req_addr", io.req_addr, 32'h0000_1004);
         chk("sw_stall_req_wdata", io.req_wdata, 32'h1234_5678);
         chk("sw_stall_req_wstrb", {28'd0, io.req_wstrb}, 32'hF);
         tick();
      end
      io.req_ready = 1'b1;
      tick();
      io.req_ready = 1'b0;
      chk("sw_req_done", {31'd0, io.req_valid}, 32'd0);
      io.resp_valid = 1'b1;
      io.resp_err = 1'b1;
      tick();
      io.resp_valid = 1'b0;
      io.resp_err = 1'b0;
      chk("sw_err", {31'd0, io.err}, 32'd1);
      chk("sw_rdata", io.rdata, 32'd0);
      chk("sw_one_handshake", hs_cnt - hs0, 32'd1);
      complete("sw");

      // Extension variants
      mem_op("lhu", 1, 0, 3'b101, 32'h8000_0002, 32'd0, 4'b0000, 32'd0,
             32'hABCD_1234, 0, 32'h0000_ABCD, 0);
      mem_op("lh", 1, 0, 3'b001, 32'h0000_0000, 32'd0, 4'b0000, 32'd0,
             32'h0000_8001, 0, 32'hFFFF_8001, 0);
      mem_op("lbu", 1, 0, 3'b100, 32'h0000_0001, 32'd0, 4'b0000, 32'd0,
             32'h0000_F100, 0, 32'h0000_00F1, 0);
      mem_op("lw_undef", 1, 0, 3'b011, 32'h0000_0004, 32'd0, 4'b0000, 32'd0,
             32'hCAFE_F00D, 0, 32'hCAFE_F00D, 0);
      mem_op("sb", 0, 1, 3'b000, 32'h0000_0002, 32'h0000_00A5, 4'b0100, 32'hA5A5_A5A5,
             32'h0, 0, 32'd0, 0);
      mem_op("ren_wen_store", 1, 1, 3'b010, 32'h0000_0008, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D,
             32'h7777_7777, 0, 32'd0, 0);

      // Timeout: no response, err after 4 cycles in WAIT
      issue(1, 0, 3'b010, 32'h0000_0010, 32'd0);
      io.req_ready = 1'b1;
      tick();
      io.req_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         if (i < 4) chk("to_not_yet", {31'd0, io.out_valid}, 32'd0);
      end
      chk("to_out_valid", {31'd0, io.out_valid}, 32'd1);
      chk("to_err", {31'd0, io.err}, 32'd1);
      chk("to_rdata", io.rdata, 32'd0);
      complete("to");

      // Reset during WAIT, then a stale response
      issue(1, 0, 3'b010, 32'h0000_0020, 32'd0);
      io.req_ready = 1'b1;
      tick();
      io.req_ready = 1'b0;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("mrst_in_ready", {31'd0, io.in_ready}, 32'd1);
      chk("mrst_out_valid", {31'd0, io.out_valid}, 32'd0);
      chk("mrst_req_addr", io.req_addr, 32'd0);
      io.resp_valid = 1'b1;
      io.resp_rdata = 32'h1111_1111;
      tick();
      io.resp_valid = 1'b0;
      chk("mrst_stale_resp", {31'd0, io.out_valid}, 32'd0);
      chk("mrst_stale_rdata", io.rdata, 32'd0);

      // Misaligned word load
`ifdef LSU_MISALIGN_CHECK_EN
      issue(1, 0, 3'b010, 32'h8000_0002, 32'd0);
      chk("mis_req_valid", {31'd0, io.req_valid}, 32'd0);
      chk("mis_out_valid", {31'd0, io.out_valid}, 32'd1);
      chk("mis_err", {31'd0, io.err}, 32'd1);
      chk("mis_rdata", io.rdata, 32'd0);
      complete("mis");
`else
      mem_op("mis", 1, 0, 3'b010, 32'h8000_0002, 32'd0, 4'b0000, 32'd0,
             32'h1122_3344, 0, 32'h0000_1122, 0);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
